// File: rtl/move_arbiter.sv
// Direction-button front end: synchronise, debounce and edge-detect four buttons,
// queue presses, and issue them one at a time round-robin over valid/ready.
module move_arbiter #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] pending,
    output logic       dropped
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    logic [3:0]       raw;
    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       db_p2;
    logic [3:0]       db_prev;
    logic [3:0]       press_p3;
    logic [CNT_W-1:0] cnt [4];

    state_t     state;
    logic [1:0] last;
    logic       grant;
    logic [1:0] grant_idx;
    logic [3:0] grant_mask;

    // First requester strictly after `from`, wrapping mod 4.
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] from);
        logic [1:0] idx;
        pick = from;
        for (int k = 3; k >= 0; k--) begin
            idx = from + 2'(k) + 2'd1;
            if (req[idx]) begin
                pick = idx;
            end
        end
    endfunction

    assign raw = {right, left, down, up};

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounce, the stable bit follows only after an unbroken run of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            db_p2 <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == db_p2[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db_p2[i] <= sync_p1[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Stage p3: rising-edge pulse of the debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            db_prev  <= '0;
            press_p3 <= '0;
        end else begin
            db_prev  <= db_p2;
            press_p3 <= db_p2 & ~db_prev;
        end
    end

    always_comb begin
        grant      = (state == IDLE) && (pending != 4'b0000);
        grant_idx  = pick(pending, last);
        grant_mask = grant ? (4'b0001 << grant_idx) : 4'b0000;
    end

    // A press landing on the bit being granted re-queues it rather than being lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            dropped <= 1'b0;
        end else begin
            pending <= (pending & ~grant_mask) | press_p3;
            if ((press_p3 & pending & ~grant_mask) != 4'b0000) begin
                dropped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            last       <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    move_valid <= 1'b0;
                    if (grant) begin
                        move_dir   <= grant_idx;
                        last       <= grant_idx;
                        move_valid <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    move_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/move_arbiter.md
# move_arbiter

Turns the four IO Shield direction buttons into a clean stream of single move commands for `game_loop`. Each button is synchronised, debounced and edge-detected, then queued as a pending request. A round-robin arbiter issues pending requests one at a time over a valid/ready handshake. The block sits between the `io_button` pins and `game_loop` in `mojo_top`. It guarantees one press produces exactly one move, even when presses collide or arrive while the game loop is busy.

## Interface
- `DEBOUNCE_CYCLES`, 500000, number of consecutive cycles a synchronised input must disagree with its debounced state before the change is accepted (10 ms at 50 MHz); minimum 2.
- `clk`  in  1  system clock, 50 MHz; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `up`  in  1  raw button, active-high, asynchronous to `clk` (`io_button[0]`).
- `down`  in  1  raw button (`io_button[2]`).
- `left`  in  1  raw button (`io_button[3]`).
- `right`  in  1  raw button (`io_button[4]`).
- `move_ready`  in  1  consumer can accept a move this cycle.
- `move_valid`  out  1  `move_dir` holds a move on offer.
- `move_dir`  out  2  0=up, 1=down, 2=left, 3=right.
- `pending`  out  4  queued but not yet issued requests; bit index equals `move_dir` code.
- `dropped`  out  1  sticky flag: a press arrived while that direction was already pending.

## Operation
- **Synchroniser:** 2-flop chain per button, reset 0.
- **Debouncer:** per button, a stable bit `db[i]` (reset 0) and a counter (reset 0, width clog2(DEBOUNCE_CYCLES)).
  - If sync equals `db`: counter <= 0.
  - Otherwise counter increments. When the counter equals DEBOUNCE_CYCLES-1 while still disagreeing, `db[i]` <= sync and the counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `db`.
- **Edge detect:** `press[i]` is a one-cycle pulse on a 0->1 transition of `db[i]`. Releases generate nothing.
- **Pending register:** `pending[i]` is set by `press[i]` and cleared when direction i is granted.
  - Grant and press of the same bit in the same cycle: bit stays 1 (the new press is queued).
  - Press while the bit is already 1 and not being granted: bit stays 1 and `dropped` <= 1.
  - `dropped` clears only on `rst`.
- **Arbiter FSM**, two states: IDLE, OFFER. Reset state IDLE.
  - IDLE: `move_valid`=0.
    - If `pending` != 0, grant the first set bit searching upward (mod 4) from `last`+1.
    - On grant: `move_dir` <= that index, `last` <= that index, clear that pending bit, go to OFFER.
    - `last` resets to 3, so after reset up has highest priority, then down, left, right.
  - OFFER: `move_valid`=1. `move_dir` is held stable until transfer.
    - On `move_valid && move_ready`: go to IDLE.
    - Otherwise stay in OFFER. There is no timeout and no withdrawal.
- **Throughput:** at most one move per 2 cycles. IDLE always lasts at least 1 cycle.
- **Reset mid-operation:** all synchronisers, debouncers, counters, `pending`, `dropped`, `last` and FSM return to reset values. An offered move is discarded.
  - A button still held at reset release is re-debounced from 0. It generates one press after DEBOUNCE_CYCLES+2 cycles.

## Timing
- Reset values: `move_valid`=0, `move_dir`=0, `pending`=0, `dropped`=0.
- Press latency, from a raw input rising edge sampled at cycle 0 to `pending[i]`=1:
  - 2 cycles of synchroniser, plus DEBOUNCE_CYCLES cycles of debounce, plus 1 cycle to register the pending bit.
  - Total: DEBOUNCE_CYCLES+3 cycles.
- `pending[i]` set at cycle n with the FSM in IDLE: the grant occurs at cycle n. `move_valid`=1 and the bit is cleared at n+1.
- Handshake: transfer occurs on a rising edge where both `move_valid` and `move_ready` are 1. `move_valid` is 0 in the following cycle.
- `move_ready` may toggle freely. It has no effect while `move_valid`=0.
- All outputs are registered. No combinational path runs from `move_ready` to any output.

## Test plan
- **Single press** (DEBOUNCE_CYCLES=4, `move_ready`=1): hold `left` high 20 cycles.
  - Exactly one `move_valid` pulse with `move_dir`=2, first asserted 8 cycles after the edge.
  - `pending` returns to 0.
  - Release produces nothing.
- **Glitch rejection:** pulse `right` high for 3 cycles, then low.
  - `pending` stays 0 and `move_valid` never asserts.
  - Repeat with 5 cycles: exactly one move with `move_dir`=3.
- **Simultaneous press:** from reset, raise all four buttons in the same cycle; `move_ready`=1.
  - Moves are issued in order 0,1,2,3, one every 2 cycles.
  - Then press `down` alone: issued as 1.
- **Backpressure:** `move_ready`=0, press `up` then `down`.
  - `move_valid`=1 with `move_dir`=0 held for 50 cycles; `pending`=4'b0010.
  - Raise `move_ready`: 0 transfers, then 1 transfers 2 cycles later.
- **Overflow:** `move_ready`=0, press `up` twice while the first move is on offer, and twice more before the second is granted.
  - `dropped`=1, and the flag remains set after both moves drain.
- **Reset mid-offer:** while `move_valid`=1 with `pending`=4'b1000, assert `rst` for 1 cycle.
  - Next cycle: `move_valid`=0, `pending`=0, `dropped`=0.
  - No move is issued afterwards unless a button is held across the reset.
